// File: rtl/evt_encoder_fifo.sv
// evt_encoder_fifo
// Turns one-hot row/column grants from the readout arbiter into binary
// (row, col) address events, optionally tagged with a free-running timestamp,
// and buffers them in a first-word-fall-through FIFO on a valid/ready stream.
// hold_o warns the arbiter one entry before the buffer fills.
// Optional feature macro: EVT_TIMESTAMP_EN (adds the TS_W-bit timestamp field).

module evt_encoder_fifo #(
    parameter int ROWS  = 4,
    parameter int COLS  = 4,
    parameter int DEPTH = 8,
    parameter int TS_W  = 16,
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1,
`ifdef EVT_TIMESTAMP_EN
    localparam bit TS_EN = 1'b1,
`else
    localparam bit TS_EN = 1'b0,
`endif
    localparam int TSW_EFF = TS_EN ? TS_W : 0,
    localparam int EW = TSW_EFF + RW + CW
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [ROWS-1:0] x_gnt_i,
    input  logic [COLS-1:0] y_gnt_i,
    output logic [EW-1:0]   evt_data_o,
    output logic            evt_valid_o,
    input  logic            evt_ready_i,
    output logic            hold_o,
    output logic [7:0]      ovf_cnt_o,
    output logic            err_o
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    logic [RW-1:0]    w_row;
    logic [CW-1:0]    w_col;
    logic             w_x_multi;
    logic             w_y_multi;
    logic             w_gnt_vld;
    logic             w_capture;
    logic             w_push;
    logic             w_pop;
    logic             w_drop;
    logic [EW-1:0]    w_evt;
    logic [CNT_W-1:0] w_count_nxt;

    logic [ROWS-1:0]  r_prev_x;
    logic [COLS-1:0]  r_prev_y;
    logic             r_prev_vld;
    logic [EW-1:0]    r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_hold;
    logic [7:0]       r_ovf;
    logic             r_err;

    // Lowest-set-bit priority encode of both grant vectors.
    always_comb begin
        w_row = '0;
        for (int i = ROWS - 1; i >= 0; i--) begin
            if (x_gnt_i[i]) w_row = RW'(i);
        end
        w_col = '0;
        for (int j = COLS - 1; j >= 0; j--) begin
            if (y_gnt_i[j]) w_col = CW'(j);
        end
    end

    // A grant is a new event only on its first cycle or when the pair changes.
    assign w_x_multi = (x_gnt_i & (x_gnt_i - ROWS'(1))) != '0;
    assign w_y_multi = (y_gnt_i & (y_gnt_i - COLS'(1))) != '0;
    assign w_gnt_vld = (x_gnt_i != '0) && (y_gnt_i != '0);
    assign w_capture = w_gnt_vld &&
                       (!r_prev_vld || (x_gnt_i != r_prev_x) || (y_gnt_i != r_prev_y));

`ifdef EVT_TIMESTAMP_EN
    logic [TS_W-1:0] r_ts;

    // Free-running timestamp; wraps naturally at its width.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_ts <= '0;
        else          r_ts <= r_ts + TS_W'(1);
    end

    assign w_evt = {r_ts, w_row, w_col};
`else
    assign w_evt = {w_row, w_col};
`endif

    // When full, a push is still accepted if the head leaves in the same cycle.
    assign w_pop  = (r_count != '0) && evt_ready_i;
    assign w_push = w_capture && ((r_count != CNT_W'(DEPTH)) || w_pop);
    assign w_drop = w_capture && !w_push;

    // Next-state occupancy, shared by the count register and hold_o.
    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop)      w_count_nxt = r_count + CNT_W'(1);
        else if (!w_push && w_pop) w_count_nxt = r_count - CNT_W'(1);
    end

    // Previous-grant history for deduplication.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_prev_x   <= '0;
            r_prev_y   <= '0;
            r_prev_vld <= 1'b0;
        end else begin
            r_prev_x   <= x_gnt_i;
            r_prev_y   <= y_gnt_i;
            r_prev_vld <= w_gnt_vld;
        end
    end

    // Storage array; contents are only observable through the count, so no reset.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= w_evt;
    end

    // Pointers, occupancy, back-pressure, overflow counter and sticky error.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_hold   <= 1'b0;
            r_ovf    <= '0;
            r_err    <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= w_count_nxt;
            r_hold  <= (w_count_nxt >= CNT_W'(DEPTH - 1));
            if (w_drop && (r_ovf != 8'hFF)) r_ovf <= r_ovf + 8'd1;
            if (w_x_multi || w_y_multi)     r_err <= 1'b1;
        end
    end

    assign evt_valid_o = (r_count != '0);
    assign evt_data_o  = evt_valid_o ? r_mem[r_rd_ptr] : '0;
    assign hold_o      = r_hold;
    assign ovf_cnt_o   = r_ovf;
    assign err_o       = r_err;

endmodule

// File: tb/tb_evt_encoder_fifo.sv
// Testbench for evt_encoder_fifo: directed scenarios plus randomized grants and
// ready, checked by a queue-based reference model and a negedge monitor.

module tb_evt_encoder_fifo;

    localparam int ROWS  = 4;
    localparam int COLS  = 4;
    localparam int DEPTH = 8;
    localparam int TS_W  = 16;
    localparam int RW    = 2;
    localparam int CW    = 2;
`ifdef EVT_TIMESTAMP_EN
    localparam int EW = TS_W + RW + CW;
`else
    localparam int EW = RW + CW;
`endif

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic [3:0]    x_gnt = '0;
    logic [3:0]    y_gnt = '0;
    logic          rdy = 1'b0;
    logic [EW-1:0] evt_data;
    logic          evt_valid;
    logic          hold;
    logic [7:0]    ovf;
    logic          err;

    int n_tests = 0;
    int n_fail  = 0;

    evt_encoder_fifo #(
        .ROWS (ROWS),
        .COLS (COLS),
        .DEPTH(DEPTH),
        .TS_W (TS_W)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .x_gnt_i    (x_gnt),
        .y_gnt_i    (y_gnt),
        .evt_data_o (evt_data),
        .evt_valid_o(evt_valid),
        .evt_ready_i(rdy),
        .hold_o     (hold),
        .ovf_cnt_o  (ovf),
        .err_o      (err)
    );

    always #5 clk = ~clk;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int lowest(logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return 0;
    endfunction

    function automatic logic [EW-1:0] mk(int ts, int row, int col);
        logic [EW-1:0] w;
        w = EW'(col) | (EW'(row) << CW);
`ifdef EVT_TIMESTAMP_EN
        w = w | (EW'(ts % 65536) << (RW + CW));
`endif
        return w;
    endfunction

    // Reference model: event list, occupancy, overflow and error at spec level.
    logic [EW-1:0] exp_q[$];
    int            count_m = 0;
    int            ovf_m = 0;
    bit            err_m = 1'b0;
    int            ts_m = 0;
    bit            prev_vld_m = 1'b0;
    logic [3:0]    prev_x_m = '0;
    logic [3:0]    prev_y_m = '0;

    bit            m_vld, m_cap, m_pop, m_drop, m_multi;
    logic [EW-1:0] m_word;

    // Decisions for the coming clock edge from the current inputs.
    always_comb begin
        m_vld   = (x_gnt != 0) && (y_gnt != 0);
        m_cap   = m_vld && (!prev_vld_m || (x_gnt != prev_x_m) || (y_gnt != prev_y_m));
        m_pop   = (count_m > 0) && rdy;
        m_drop  = m_cap && (count_m == DEPTH) && !m_pop;
        m_multi = ($countones(x_gnt) > 1) || ($countones(y_gnt) > 1);
        m_word  = mk(ts_m, lowest(x_gnt), lowest(y_gnt));
    end

    // Model state update at each clock edge, cleared by the async reset.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            exp_q.delete();
            count_m    <= 0;
            ovf_m      <= 0;
            err_m      <= 1'b0;
            ts_m       <= 0;
            prev_vld_m <= 1'b0;
            prev_x_m   <= '0;
            prev_y_m   <= '0;
        end else begin
            if (m_cap && !m_drop) exp_q.push_back(m_word);
            count_m    <= count_m + ((m_cap && !m_drop) ? 1 : 0) - (m_pop ? 1 : 0);
            if (m_drop && ovf_m < 255) ovf_m <= ovf_m + 1;
            if (m_multi) err_m <= 1'b1;
            ts_m       <= (ts_m + 1) % 65536;
            prev_vld_m <= m_vld;
            prev_x_m   <= x_gnt;
            prev_y_m   <= y_gnt;
        end
    end

    // Monitor: compares DUT outputs mid-cycle and pops the scoreboard on handshake.
    always @(negedge clk) begin
        if (!reset_n) begin
            chk("rst_valid", 32'(evt_valid), 0);
            chk("rst_hold",  32'(hold), 0);
            chk("rst_ovf",   32'(ovf), 0);
            chk("rst_err",   32'(err), 0);
            chk("rst_data",  32'(evt_data), 0);
        end else begin
            chk("valid", 32'(evt_valid), 32'(count_m > 0));
            chk("hold",  32'(hold), 32'(count_m >= DEPTH - 1));
            chk("ovf",   32'(ovf), 32'(ovf_m));
            chk("err",   32'(err), 32'(err_m));
            if (count_m > 0 && exp_q.size() > 0) begin
                chk("data", 32'(evt_data), 32'(exp_q[0]));
                if (rdy) void'(exp_q.pop_front());
            end
        end
    end

    task automatic step(logic [3:0] x, logic [3:0] y, logic r);
        x_gnt = x;
        y_gnt = y;
        rdy   = r;
        @(posedge clk);
        #1;
    endtask

    int pct [6] = '{80, 20, 60, 10, 90, 50};

    initial begin
        #1 reset_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 reset_n = 1'b1;
        chk("rel_valid", 32'(evt_valid), 0);
        chk("rel_data",  32'(evt_data), 0);

        // Single event captured while the timestamp reads 5.
        for (int i = 0; i < 5; i++) step(4'b0000, 4'b0000, 1'b0);
        step(4'b0100, 4'b0010, 1'b0);
        chk("single_valid", 32'(evt_valid), 1);
        chk("single_data",  32'(evt_data), 32'(mk(5, 2, 1)));
        step(4'b0000, 4'b0000, 1'b1);
        chk("single_drained", 32'(evt_valid), 0);

        // Held grant gives one event; changing the column gives a second.
        for (int i = 0; i < 3; i++) step(4'b0100, 4'b0010, 1'b0);
        step(4'b0100, 4'b1000, 1'b0);
        step(4'b0000, 4'b0000, 1'b0);
        step(4'b0000, 4'b0000, 1'b1);
        chk("held_second_col", 32'(evt_data[CW-1:0]), 3);
        step(4'b0000, 4'b0000, 1'b1);
        chk("held_two_only", 32'(evt_valid), 0);

        // Back-pressure: nine distinct events with the consumer stalled.
        for (int i = 1; i <= 9; i++) begin
            step(4'(1 << ((i - 1) % 4)), 4'(1 << ((i - 1) / 4)), 1'b0);
            if (i == 6) chk("bp_hold_at6", 32'(hold), 0);
            if (i == 7) chk("bp_hold_at7", 32'(hold), 1);
        end
        chk("bp_ovf", 32'(ovf), 1);
        for (int i = 1; i <= 8; i++) begin
            step(4'b0000, 4'b0000, 1'b1);
            if (i == 1) chk("bp_hold_cnt7", 32'(hold), 1);
            if (i == 2) chk("bp_hold_cnt6", 32'(hold), 0);
        end
        chk("bp_empty", 32'(evt_valid), 0);

        // Non-one-hot row grant: encoded from the lowest bit, error stays set.
        step(4'b0110, 4'b0001, 1'b0);
        chk("bad_err", 32'(err), 1);
        chk("bad_data", 32'(evt_data), 32'(mk(ts_m - 1, 1, 0)));
        step(4'b0000, 4'b0000, 1'b1);
        step(4'b0000, 4'b0000, 1'b1);
        chk("bad_err_sticky", 32'(err), 1);

        // Reset in the middle of operation with three events buffered.
        step(4'b0001, 4'b0001, 1'b0);
        step(4'b0010, 4'b0001, 1'b0);
        step(4'b0100, 4'b0001, 1'b0);
        x_gnt = '0;
        y_gnt = '0;
        #2 reset_n = 1'b0;
        #1;
        chk("midrst_valid", 32'(evt_valid), 0);
        chk("midrst_ovf",   32'(ovf), 0);
        chk("midrst_err",   32'(err), 0);
        #3 reset_n = 1'b1;
        @(posedge clk);
        #1;
        step(4'b0001, 4'b0001, 1'b1);
        chk("midrst_ts_restart", 32'(evt_data), 32'(mk(1, 0, 0)));
        step(4'b0000, 4'b0000, 1'b1);

        // Randomized grants and ready with varying consumer throughput.
        for (int b = 0; b < 6; b++) begin
            for (int i = 0; i < 400; i++) begin
                int r;
                logic [3:0] nx, ny;
                r  = $urandom_range(0, 99);
                nx = x_gnt;
                ny = y_gnt;
                if (r < 35) begin
                end else if (r < 47) begin
                    nx = ($urandom_range(0, 1) != 0) ? 4'(1 << $urandom_range(0, 3)) : 4'b0000;
                    ny = 4'b0000;
                end else if (r < 49) begin
                    nx = 4'($urandom_range(1, 15));
                    ny = 4'($urandom_range(1, 15));
                end else begin
                    nx = 4'(1 << $urandom_range(0, 3));
                    ny = 4'(1 << $urandom_range(0, 3));
                end
                step(nx, ny, $urandom_range(0, 99) < pct[b]);
            end
        end

        for (int i = 0; i < 12; i++) step(4'b0000, 4'b0000, 1'b1);
        chk("final_empty", 32'(evt_valid), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
